// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer sitting behind the UART receiver.
// Stores {bi, fe, pe, data} per character and presents the head entry
// first-word-fall-through. It produces trigger-level, overrun and
// error-in-FIFO status.
// Optional macro UART_RX_FIFO_TIMEOUT_EN adds the character-timeout counter.
// When the macro is undefined, timeout is tied to 0.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_en,
    input  logic                     clr,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pe_in,
    input  logic                     fe_in,
    input  logic                     bi_in,
    input  logic                     pop,
    input  logic [1:0]               trig,
    input  logic                     ovr_clr,
    input  logic                     baud_pulse,
    output logic [7:0]               dout,
    output logic                     pe_out,
    output logic                     fe_out,
    output logic                     bi_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     thr,
    output logic                     overrun,
    output logic                     err_in_fifo,
    output logic                     timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [NW-1:0] cap;
    logic [NW-1:0] err_cnt;
    logic          en_q;
    logic          flush;
    logic          do_push;
    logic          do_pop;
    logic          lost;
    logic          wr_err;
    logic          rd_err;
    logic [CW-1:0] head;
    int unsigned   lvl;

    // Capacity, flush and accept/drop decisions for the current edge.
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        cap     = fifo_en ? NW'(DEPTH) : NW'(1);
        flush   = clr | (fifo_en != en_q);
        do_pop  = pop & (count != '0);
        do_push = push & ((count < cap) | do_pop);
        lost    = push & ~do_push;
        head    = mem[rd_ptr];
        wr_err  = bi_in | fe_in | pe_in;
        rd_err  = |head[10:8];
    end

    // Storage array; entries outside [rd_ptr, wr_ptr) are don't-care.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= {bi_in, fe_in, pe_in, din};
        end
    end

    // Pointers, occupancy, error-entry counter and sticky overrun.
    always_ff @(posedge clk) begin
        en_q <= fifo_en;
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + NW'(1);
            else if (do_pop && !do_push) count <= count - NW'(1);
            unique case ({do_push & wr_err, do_pop & rd_err})
                2'b10:   err_cnt <= err_cnt + NW'(1);
                2'b01:   err_cnt <= err_cnt - NW'(1);
                default: err_cnt <= err_cnt;
            endcase
            if (lost)         overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    // Head-entry view and combinational status flags.
    always_comb begin
        empty       = (count == '0);
        full        = (count == cap);
        dout        = empty ? '0   : head[7:0];
        pe_out      = empty ? 1'b0 : head[8];
        fe_out      = empty ? 1'b0 : head[9];
        bi_out      = empty ? 1'b0 : head[10];
        err_in_fifo = (err_cnt != '0);
        unique case (trig)
            2'b00:   lvl = 1;
            2'b01:   lvl = 4;
            2'b10:   lvl = 8;
            default: lvl = 14;
        endcase
        thr = fifo_en ? (32'(count) >= lvl) : !empty;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [9:0] ticks;

    // Character timeout: counts baud ticks while data waits with no traffic.
    // The counter saturates at 640, which is 4 characters of 10 bits at 16 ticks per bit.
    always_ff @(posedge clk) begin
        if (rst || flush || push || pop) begin
            ticks   <= '0;
            timeout <= 1'b0;
        end else if (count == '0) begin
            ticks <= '0;
        end else if (baud_pulse && ticks != 10'd640) begin
            ticks <= ticks + 10'd1;
            if (ticks == 10'd639) timeout <= 1'b1;
        end
    end
`else
    logic unused_baud;

    // Timeout feature compiled out.
    always_comb begin
        timeout     = 1'b0;
        unused_baud = baud_pulse;
    end
`endif

endmodule
